// File: rtl/score_pkg.sv
// Shared FSM encoding and sizing defaults for the score scheduler.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_PEND_W    = 3;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requesting lane at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [LANE_W-1:0]    ptr,
    output logic [NUM_LANES-1:0] gnt,
    output logic [LANE_W-1:0]    gnt_idx
);

    logic found;
    int   lane;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        lane    = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane = (int'(ptr) + i) % NUM_LANES;
            if (!found && req[lane]) begin
                found     = 1'b1;
                gnt[lane] = 1'b1;
                gnt_idx   = LANE_W'(lane);
            end
        end
    end

endmodule

// File: rtl/score_scheduler.sv
// Game-state FSM that queues per-lane tile hits and serialises them into
// single-point inc pulses for the score datapath, one lane per cycle.
module score_scheduler
    import score_pkg::*;
#(
    parameter int  NUM_LANES = DEF_NUM_LANES,
    parameter int  PEND_W    = DEF_PEND_W,
    localparam int LANE_W    = lane_w(NUM_LANES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 miss,
    input  logic [NUM_LANES-1:0] hit,
    output logic                 clr,
    output logic                 inc,
    output logic [LANE_W-1:0]    inc_lane,
    output logic [1:0]           state,
    output logic                 game_over,
    output logic                 drop_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t               cur_st, nxt_st;
    logic [PEND_W-1:0]    pend_cnt [NUM_LANES];
    logic [LANE_W-1:0]    rr_ptr;
    logic [NUM_LANES-1:0] req, gnt, hit_acc, sat_vec;
    logic [LANE_W-1:0]    gnt_idx;
    logic                 start_acc, serve_en, pend_zero, gnt_any, drop_any;

    // Hit and grant on the same lane cancel; a hit on a full counter is lost.
    function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                    input logic hit_in,
                                                    input logic gnt_in);
        logic [PEND_W-1:0] res;
        res = cur;
        if (hit_in && !gnt_in && cur != PEND_MAX) res = cur + 1'b1;
        else if (!hit_in && gnt_in)               res = cur - 1'b1;
        return res;
    endfunction

    function automatic logic [LANE_W-1:0] ptr_wrap(input logic [LANE_W-1:0] idx);
        return (idx == LANE_W'(NUM_LANES - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        pend_zero = 1'b1;
        req       = '0;
        sat_vec   = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            req[l]     = serve_en && (pend_cnt[l] != '0);
            sat_vec[l] = (pend_cnt[l] == PEND_MAX);
            if (pend_cnt[l] != '0) pend_zero = 1'b0;
        end
    end

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign gnt_any  = |gnt;
    assign drop_any = |(hit_acc & ~gnt & sat_vec);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur_st <= ST_IDLE;
        else       cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st    = cur_st;
        start_acc = 1'b0;
        serve_en  = 1'b0;
        hit_acc   = '0;
        case (cur_st)
            ST_IDLE: begin
                if (start) begin
                    nxt_st    = ST_PLAY;
                    start_acc = 1'b1;
                end
            end
            ST_PLAY: begin
                serve_en = 1'b1;
                hit_acc  = hit;
                if (miss) nxt_st = ST_DRAIN;
            end
            ST_DRAIN: begin
                serve_en = 1'b1;
                // Empty counters mean the arbiter cannot grant this cycle.
                if (pend_zero) nxt_st = ST_OVER;
            end
            ST_OVER: begin
                if (start) begin
                    nxt_st    = ST_PLAY;
                    start_acc = 1'b1;
                end
            end
            default: nxt_st = ST_IDLE;
        endcase
    end

    // Grant stage: counters, pointer and the registered score pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < NUM_LANES; l++) pend_cnt[l] <= '0;
            rr_ptr   <= '0;
            clr      <= 1'b0;
            inc      <= 1'b0;
            inc_lane <= '0;
            drop_err <= 1'b0;
        end else begin
            clr      <= start_acc;
            inc      <= gnt_any;
            inc_lane <= gnt_any ? gnt_idx : '0;
            if (start_acc) begin
                for (int l = 0; l < NUM_LANES; l++) pend_cnt[l] <= '0;
                rr_ptr   <= '0;
                drop_err <= 1'b0;
            end else begin
                for (int l = 0; l < NUM_LANES; l++)
                    pend_cnt[l] <= pend_next(pend_cnt[l], hit_acc[l], gnt[l]);
                if (gnt_any)  rr_ptr   <= ptr_wrap(gnt_idx);
                if (drop_any) drop_err <= 1'b1;
            end
        end
    end

    assign state     = cur_st;
    assign game_over = (cur_st == ST_OVER);

endmodule

// File: tb/tb_score_scheduler.sv
// Bench for score_scheduler: directed game scenarios plus random traffic,
// each compared cycle by cycle with a behavioural game model.
module tb_score_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       miss  = 1'b0;
    logic [3:0] hit   = 4'b0;
    logic       clr, inc, game_over, drop_err;
    logic [1:0] inc_lane;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // Behavioural model: game phase, pending hits per lane, next lane to serve.
    int m_state;
    int m_ptr;
    int m_cnt [4];
    int m_lane;
    bit m_clr, m_inc, m_drop;

    score_scheduler #(.NUM_LANES(4), .PEND_W(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .miss      (miss),
        .hit       (hit),
        .clr       (clr),
        .inc       (inc),
        .inc_lane  (inc_lane),
        .state     (state),
        .game_over (game_over),
        .drop_err  (drop_err)
    );

    always #5 clock = ~clock;

    logic [7:0] obs;
    assign obs = {clr, inc, inc_lane, state, game_over, drop_err};

    function automatic logic [7:0] exp_vec();
        return {m_clr, m_inc, 2'(m_lane), 2'(m_state), (m_state == 3), m_drop};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_lane = 0;
        m_clr = 0; m_inc = 0; m_drop = 0;
        for (int l = 0; l < 4; l++) m_cnt[l] = 0;
    endtask

    task automatic model_step(input bit s, input bit m, input logic [3:0] h);
        bit acc_s, dr, empty;
        int g, l, c;
        acc_s = s && (m_state == 0 || m_state == 3);
        g = -1;
        empty = 1;
        for (int i = 0; i < 4; i++) if (m_cnt[i] != 0) empty = 0;
        if (m_state == 1 || m_state == 2)
            for (int i = 0; i < 4; i++) begin
                l = (m_ptr + i) % 4;
                if (g < 0 && m_cnt[l] > 0) g = l;
            end
        dr = 0;
        for (int i = 0; i < 4; i++) begin
            c = m_cnt[i];
            if (i == g) c = c - 1;
            if (m_state == 1 && h[i]) begin
                if (c == 7) dr = 1;
                else        c = c + 1;
            end
            m_cnt[i] = acc_s ? 0 : c;
        end
        m_inc  = (g >= 0);
        m_lane = (g >= 0) ? g : 0;
        m_clr  = acc_s;
        m_drop = acc_s ? 0 : (m_drop | dr);
        if (acc_s)       m_ptr = 0;
        else if (g >= 0) m_ptr = (g + 1) % 4;
        case (m_state)
            0: if (s) m_state = 1;
            1: if (m) m_state = 2;
            2: if (empty) m_state = 3;
            3: if (s) m_state = 1;
            default: m_state = 0;
        endcase
    endtask

    task automatic tick(input bit s, input bit m, input logic [3:0] h);
        @(negedge clock);
        start = s; miss = m; hit = h;
        model_step(s, m, h);
        @(posedge clock);
        #1;
        start = 0; miss = 0; hit = 4'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        model_reset();
        total++;
        if (obs !== 8'h00) begin
            bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 8'h00);
        end
        do_reset();
        total++;
        if (obs !== exp_vec()) begin
            bad++; $display("FAIL reset_release got=%b want=%b", obs, exp_vec());
        end
    endtask

    task automatic test_single_hit();
        int n_inc = 0;
        int first = -1;
        do_reset();
        tick(1, 0, 4'b0);
        total++;
        if (clr !== 1'b1 || state !== 2'd1) begin
            bad++; $display("FAIL start_clr clr=%b state=%0d want clr=1 state=1", clr, state);
        end
        tick(0, 0, 4'b0001);
        total++;
        if (clr !== 1'b0 || inc !== 1'b0) begin
            bad++; $display("FAIL clr_one_cycle clr=%b inc=%b want 0 0", clr, inc);
        end
        for (int c = 0; c < 6; c++) begin
            tick(0, 0, 4'b0);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL single_hit c=%0d got=%b want=%b", c, obs, exp_vec());
            end
            if (inc) begin
                n_inc++;
                if (first < 0) first = c;
            end
        end
        total++;
        if (n_inc !== 1 || first !== 0) begin
            bad++; $display("FAIL single_hit_latency incs=%0d first=%0d want 1 0", n_inc, first);
        end
    endtask

    task automatic test_all_lanes();
        int lanes[$];
        do_reset();
        tick(1, 0, 4'b0);
        tick(0, 0, 4'b1111);
        for (int c = 0; c < 6; c++) begin
            tick(0, 0, 4'b0);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL all_lanes c=%0d got=%b want=%b", c, obs, exp_vec());
            end
            if (inc) lanes.push_back(int'(inc_lane));
        end
        total++;
        if (lanes.size() != 4 || lanes[0] != 0 || lanes[1] != 1 || lanes[2] != 2 || lanes[3] != 3) begin
            bad++; $display("FAIL all_lanes_order got=%p want='{0,1,2,3}", lanes);
        end
    endtask

    task automatic test_lane2_stream();
        int n_inc = 0;
        do_reset();
        tick(1, 0, 4'b0);
        for (int c = 0; c < 21; c++) begin
            tick(0, 0, (c < 9) ? 4'b0100 : 4'b0000);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL lane2_stream c=%0d got=%b want=%b", c, obs, exp_vec());
            end
            if (inc) n_inc++;
        end
        total++;
        if (n_inc !== 9 || drop_err !== 1'b0) begin
            bad++; $display("FAIL lane2_count incs=%0d drop_err=%b want 9 0", n_inc, drop_err);
        end
    endtask

    task automatic test_saturation();
        int lanes[$];
        bit alt_ok = 1;
        do_reset();
        tick(1, 0, 4'b0);
        for (int c = 0; c < 16; c++) begin
            tick(0, 0, 4'b0011);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL saturation c=%0d got=%b want=%b", c, obs, exp_vec());
            end
            if (inc) lanes.push_back(int'(inc_lane));
        end
        for (int i = 0; i < lanes.size(); i++) if (lanes[i] != (i % 2)) alt_ok = 0;
        total++;
        if (!alt_ok || lanes.size() != 15 || drop_err !== 1'b1) begin
            bad++; $display("FAIL saturation_end alt=%0d incs=%0d drop_err=%b want 1 15 1",
                            alt_ok, lanes.size(), drop_err);
        end
    endtask

    task automatic test_drain();
        int n_inc = 0;
        do_reset();
        tick(1, 0, 4'b0);
        tick(0, 0, 4'b0111);
        tick(0, 1, 4'b0);
        if (inc) n_inc++;
        total++;
        if (state !== 2'd2) begin
            bad++; $display("FAIL drain_enter state=%0d want 2", state);
        end
        for (int c = 0; c < 7; c++) begin
            tick(0, 0, 4'b1111);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL drain c=%0d got=%b want=%b", c, obs, exp_vec());
            end
            if (inc) n_inc++;
        end
        total++;
        if (n_inc !== 3 || state !== 2'd3 || game_over !== 1'b1) begin
            bad++; $display("FAIL drain_over incs=%0d state=%0d game_over=%b want 3 3 1",
                            n_inc, state, game_over);
        end
    endtask

    task automatic test_reset_mid_drain();
        int n_inc = 0;
        do_reset();
        tick(1, 0, 4'b0);
        tick(0, 0, 4'b1111);
        tick(0, 0, 4'b1111);
        tick(0, 1, 4'b0);
        tick(0, 0, 4'b0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        total++;
        if (obs !== 8'h00) begin
            bad++; $display("FAIL async_reset got=%b want=%b", obs, 8'h00);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(0, 0, 4'b0);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL post_reset c=%0d got=%b want=%b", c, obs, exp_vec());
            end
            if (inc) n_inc++;
        end
        total++;
        if (n_inc !== 0 || state !== 2'd0) begin
            bad++; $display("FAIL post_reset_idle incs=%0d state=%0d want 0 0", n_inc, state);
        end
    endtask

    task automatic test_random();
        bit s, m;
        logic [3:0] h;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            s = ($urandom % 25) == 0;
            m = ($urandom % 30) == 0;
            h = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            tick(s, m, h);
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random c=%0d got=%b want=%b", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_all_lanes();
        test_lane2_stream();
        test_saturation();
        test_drain();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
